// File: rtl/ibex_fetch_unit.sv
// Instruction-fetch stage: redirect address generation, request/grant/rvalid bus
// handling with stale-response discard, a small response FIFO and the ID register.
module ibex_fetch_unit #(
    parameter int          FIFO_DEPTH   = 2,
    parameter logic [31:0] DM_HALT_ADDR = 32'h1A110800,
    parameter logic [31:0] DM_EXC_ADDR  = 32'h1A110808
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        pc_set_i,
    input  logic [2:0]  pc_mux_i,
    input  logic [1:0]  exc_pc_mux_i,
    input  logic [5:0]  exc_cause_i,
    input  logic [31:0] boot_addr_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_depc_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    input  logic        id_in_ready_i,
    input  logic        instr_valid_clear_i,
    output logic        instr_valid_id_o,
    output logic [31:0] instr_rdata_id_o,
    output logic [31:0] pc_id_o,
    output logic        instr_fetch_err_o,
    output logic        if_busy_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {PC_BOOT, PC_JUMP, PC_EXC, PC_ERET, PC_DRET} pc_sel_e;
    typedef enum logic [1:0] {EXC_PC_EXC, EXC_PC_IRQ, EXC_PC_DBD, EXC_PC_DBG_EXC} exc_pc_sel_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] pc;
    } entry_t;

    logic [31:0]      fetch_addr_q, resp_addr_q;
    logic [31:0]      target_raw, target;
    logic [CNT_W-1:0] outstanding_q, discard_q, fifo_cnt_q, wr_idx;
    logic             err_stop_q;
    entry_t           fifo_q [FIFO_DEPTH];
    entry_t           resp_entry, id_entry, id_q;
    logic             id_valid_q;
    logic             req_gnt, rvalid_live, drop, accept, bypass, push, pop, id_load, fifo_empty;
    logic             unused_bits;

    assign unused_bits = ^{exc_cause_i[5], csr_mtvec_i[7:0]};

    always_comb begin
        target_raw = boot_addr_i + 32'h80;
        case (pc_sel_e'(pc_mux_i))
            PC_JUMP: target_raw = jump_target_i;
            PC_ERET: target_raw = csr_mepc_i;
            PC_DRET: target_raw = csr_depc_i;
            PC_EXC: begin
                case (exc_pc_sel_e'(exc_pc_mux_i))
                    EXC_PC_EXC: target_raw = {csr_mtvec_i[31:8], 8'h00};
                    EXC_PC_IRQ: target_raw = {csr_mtvec_i[31:8], 1'b0, exc_cause_i[4:0], 2'b00};
                    EXC_PC_DBD: target_raw = DM_HALT_ADDR;
                    default:    target_raw = DM_EXC_ADDR;
                endcase
            end
            default: target_raw = boot_addr_i + 32'h80;
        endcase
        target = target_raw & ~32'h3;
    end

    // Outstanding plus buffered never exceeds the FIFO, so every accepted response has a slot.
    assign instr_req_o  = req_i & ~pc_set_i & ~err_stop_q &
                          (({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < (CNT_W + 1)'(FIFO_DEPTH));
    assign instr_addr_o = fetch_addr_q;
    assign if_busy_o    = instr_req_o | (outstanding_q != '0);

    // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
    assign req_gnt     = instr_req_o & instr_gnt_i;
    assign rvalid_live = instr_rvalid_i & (outstanding_q != '0);
    assign drop        = rvalid_live & (discard_q != '0);
    assign accept      = rvalid_live & (discard_q == '0);
    assign resp_entry  = '{rdata: instr_rdata_i, err: instr_err_i, pc: resp_addr_q};

    assign fifo_empty = (fifo_cnt_q == '0);
    assign pop        = ~pc_set_i & id_in_ready_i & ~fifo_empty;
    assign bypass     = ~pc_set_i & id_in_ready_i & fifo_empty & accept;
    assign push       = ~pc_set_i & accept & ~bypass;
    assign id_load    = pop | bypass;
    assign id_entry   = fifo_empty ? resp_entry : fifo_q[0];
    assign wr_idx     = fifo_cnt_q - CNT_W'(pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_addr_q  <= '0;
            resp_addr_q   <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            fifo_cnt_q    <= '0;
            err_stop_q    <= 1'b0;
            id_valid_q    <= 1'b0;
            id_q          <= '0;
        end else begin
            outstanding_q <= outstanding_q + CNT_W'(req_gnt) - CNT_W'(rvalid_live);
            if (pc_set_i) begin
                fetch_addr_q <= target;
                resp_addr_q  <= target;
                discard_q    <= outstanding_q - CNT_W'(rvalid_live);
                fifo_cnt_q   <= '0;
                err_stop_q   <= 1'b0;
                id_valid_q   <= 1'b0;
            end else begin
                if (req_gnt) fetch_addr_q <= fetch_addr_q + 32'd4;
                if (accept)  resp_addr_q  <= resp_addr_q + 32'd4;
                if (drop)    discard_q    <= discard_q - CNT_W'(1);
                if (accept && instr_err_i) err_stop_q <= 1'b1;
                fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
                if (id_load) begin
                    id_valid_q <= 1'b1;
                    id_q       <= id_entry;
                end else if (instr_valid_clear_i) begin
                    id_valid_q <= 1'b0;
                end
            end
        end
    end

    // Shift-register FIFO: head is always entry 0.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (push && wr_idx == CNT_W'(i)) begin
                fifo_q[i] <= resp_entry;
            end else if (pop && i < FIFO_DEPTH - 1) begin
                fifo_q[i] <= fifo_q[(i + 1) % FIFO_DEPTH];
            end
        end
    end

    assign instr_valid_id_o  = id_valid_q;
    assign instr_rdata_id_o  = id_q.rdata;
    assign pc_id_o           = id_q.pc;
    assign instr_fetch_err_o = id_q.err;

endmodule

// File: tb/tb_ibex_fetch_unit.sv
// Scoreboard bench for ibex_fetch_unit: queue-based fetch model, directed scenarios then random traffic.
module tb_ibex_fetch_unit;
    localparam int FIFO_DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni, req_i, pc_set_i;
    logic [2:0]  pc_mux_i;
    logic [1:0]  exc_pc_mux_i;
    logic [5:0]  exc_cause_i;
    logic [31:0] boot_addr_i, jump_target_i, csr_mtvec_i, csr_mepc_i, csr_depc_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0] instr_rdata_i;
    logic        id_in_ready_i, instr_valid_clear_i;
    logic        instr_valid_id_o, instr_fetch_err_o, if_busy_o;
    logic [31:0] instr_rdata_id_o, pc_id_o;

    ibex_fetch_unit #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .pc_set_i(pc_set_i),
        .pc_mux_i(pc_mux_i), .exc_pc_mux_i(exc_pc_mux_i), .exc_cause_i(exc_cause_i),
        .boot_addr_i(boot_addr_i), .jump_target_i(jump_target_i), .csr_mtvec_i(csr_mtvec_i),
        .csr_mepc_i(csr_mepc_i), .csr_depc_i(csr_depc_i), .instr_req_o(instr_req_o),
        .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i), .id_in_ready_i(id_in_ready_i),
        .instr_valid_clear_i(instr_valid_clear_i), .instr_valid_id_o(instr_valid_id_o),
        .instr_rdata_id_o(instr_rdata_id_o), .pc_id_o(pc_id_o),
        .instr_fetch_err_o(instr_fetch_err_o), .if_busy_o(if_busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        err;
    } ent_t;
    typedef struct {
        logic [31:0] addr;
        logic        live;
    } req_t;

    // Reference model: bus requests in flight, buffered responses, ID state.
    req_t        m_out[$];
    ent_t        m_fifo[$];
    ent_t        exp_q[$];
    logic [31:0] m_addr;
    logic        m_stop, m_idv;
    int          checks = 0, errors = 0;
    int unsigned seq = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] tgt();
        logic [31:0] t;
        case (pc_mux_i)
            3'd1: t = jump_target_i;
            3'd2: case (exc_pc_mux_i)
                      2'd0: t = {csr_mtvec_i[31:8], 8'h00};
                      2'd1: t = {csr_mtvec_i[31:8], 1'b0, exc_cause_i[4:0], 2'b00};
                      2'd2: t = 32'h1A110800;
                      default: t = 32'h1A110808;
                  endcase
            3'd3: t = csr_mepc_i;
            3'd4: t = csr_depc_i;
            default: t = boot_addr_i + 32'h80;
        endcase
        return {t[31:2], 2'b00};
    endfunction

    task automatic model_step(input logic exp_req);
        req_t r;
        ent_t e;
        if (!rst_ni) begin
            m_out.delete(); m_fifo.delete();
            m_addr = '0; m_stop = 1'b0; m_idv = 1'b0;
        end else if (pc_set_i) begin
            if (instr_rvalid_i && m_out.size() > 0) r = m_out.pop_front();
            foreach (m_out[i]) m_out[i].live = 1'b0;
            m_fifo.delete();
            m_idv = 1'b0; m_stop = 1'b0; m_addr = tgt();
        end else begin
            if (instr_rvalid_i && m_out.size() > 0) begin
                r = m_out.pop_front();
                if (r.live) begin
                    m_fifo.push_back('{rdata: instr_rdata_i, pc: r.addr, err: instr_err_i});
                    if (instr_err_i) m_stop = 1'b1;
                end
            end
            if (exp_req && instr_gnt_i) begin
                m_out.push_back('{addr: m_addr, live: 1'b1});
                m_addr = m_addr + 32'd4;
            end
            if (id_in_ready_i && m_fifo.size() > 0) begin
                e = m_fifo.pop_front();
                exp_q.push_back(e);
                m_idv = 1'b1;
            end else if (instr_valid_clear_i) begin
                m_idv = 1'b0;
            end
        end
    endtask

    // One clock cycle with the inputs currently driven; checks bus and ID status mid-cycle.
    task automatic tick();
        logic exp_req;
        if (instr_rvalid_i) begin
            instr_rdata_i = 32'hC000_0000 + seq;
            seq++;
        end
        exp_req = req_i && !pc_set_i && !m_stop && (m_out.size() + m_fifo.size() < FIFO_DEPTH);
        #2;
        chk("instr_req", 32'(instr_req_o), 32'(exp_req));
        if (exp_req) chk("instr_addr", instr_addr_o, m_addr);
        chk("id_valid", 32'(instr_valid_id_o), 32'(m_idv));
        chk("if_busy", 32'(if_busy_o), 32'(exp_req || m_out.size() != 0));
        @(posedge clk_i);
        model_step(exp_req);
        #1;
    endtask

    task automatic auto_rvalid(input logic [31:0] err_pc);
        instr_rvalid_i = (m_out.size() != 0);
        instr_err_i    = instr_rvalid_i && m_out[0].live && (m_out[0].addr == err_pc);
    endtask

    task automatic wait_valid(input bit any_pc, input logic [31:0] pc, input logic [31:0] err_pc,
                              output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 30 && !ok; c++) begin
            instr_gnt_i = 1'b1;
            auto_rvalid(err_pc);
            tick();
            if (instr_valid_id_o && (any_pc || pc_id_o == pc)) ok = 1'b1;
        end
        instr_rvalid_i = 1'b0;
        instr_err_i    = 1'b0;
    endtask

    task automatic redirect(input logic [2:0] mux, input logic [31:0] jt);
        pc_set_i = 1'b1; pc_mux_i = mux; jump_target_i = jt;
        tick();
        pc_set_i = 1'b0;
    endtask

    // Scoreboard monitor: each new instruction appearing in ID is matched against the model.
    initial begin
        ent_t last, cur;
        last = '0;
        forever begin
            @(negedge clk_i);
            if (instr_valid_id_o === 1'b1) begin
                cur = '{rdata: instr_rdata_id_o, pc: pc_id_o, err: instr_fetch_err_o};
                if (cur !== last) begin
                    if (exp_q.size() == 0) begin
                        chk("id_unexpected", cur.pc, 32'hFFFF_FFFF);
                    end else begin
                        ent_t e;
                        e = exp_q.pop_front();
                        chk("id_rdata", cur.rdata, e.rdata);
                        chk("id_pc", cur.pc, e.pc);
                        chk("id_err", 32'(cur.err), 32'(e.err));
                    end
                    last = cur;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int grants;
        rst_ni = 1'b0; req_i = 1'b0; pc_set_i = 1'b0; pc_mux_i = '0; exc_pc_mux_i = '0;
        exc_cause_i = '0; boot_addr_i = '0; jump_target_i = '0; csr_mtvec_i = '0;
        csr_mepc_i = '0; csr_depc_i = '0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
        instr_rdata_i = '0; instr_err_i = 1'b0; id_in_ready_i = 1'b0; instr_valid_clear_i = 1'b0;
        m_addr = '0; m_stop = 1'b0; m_idv = 1'b0;
        @(posedge clk_i); @(posedge clk_i); #1;
        chk("rst_req", 32'(instr_req_o), 32'd0);
        chk("rst_addr", instr_addr_o, 32'd0);
        chk("rst_valid", 32'(instr_valid_id_o), 32'd0);
        chk("rst_busy", 32'(if_busy_o), 32'd0);
        rst_ni = 1'b1;

        // Boot with immediate grant and response
        req_i = 1'b1; id_in_ready_i = 1'b1;
        redirect(3'd0, '0);
        instr_gnt_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr_rvalid_i = (m_out.size() != 0);
            #1;
            chk("boot_addr", instr_addr_o, 32'h80 + 32'(4 * k));
            if (k == 2) begin
                chk("boot_valid_n3", 32'(instr_valid_id_o), 32'd1);
                chk("boot_pc_n3", pc_id_o, 32'h80);
            end
            tick();
        end

        // Vectored interrupt
        csr_mtvec_i = 32'h0000_1000; exc_cause_i = 6'h27; exc_pc_mux_i = 2'd1;
        instr_gnt_i = 1'b0; instr_rvalid_i = (m_out.size() != 0);
        redirect(3'd2, '0);
        instr_rvalid_i = 1'b0;
        #1;
        chk("irq_req", 32'(instr_req_o), 32'd1);
        chk("irq_addr", instr_addr_o, 32'h101C);
        tick();

        // Flush with two requests in flight
        redirect(3'd0, '0);
        instr_gnt_i = 1'b1;
        tick(); tick();
        chk("flush_outstanding", 32'(m_out.size()), 32'd2);
        instr_gnt_i = 1'b0;
        redirect(3'd1, 32'h200);
        wait_valid(1'b1, '0, 32'hFFFF_FFFF, ok);
        chk("flush_seen", 32'(ok), 32'd1);
        chk("flush_first_pc", pc_id_o, 32'h200);

        // Backpressure: FIFO fills, requests stop, drain in order
        id_in_ready_i = 1'b0;
        redirect(3'd0, '0);
        grants = 0;
        instr_gnt_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            instr_rvalid_i = (m_out.size() != 0);
            #1;
            if (instr_req_o && instr_gnt_i) grants++;
            tick();
        end
        chk("bp_grants", 32'(grants), 32'd2);
        chk("bp_req_stopped", 32'(instr_req_o), 32'd0);
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; id_in_ready_i = 1'b1;
        tick();
        chk("bp_drain0", pc_id_o, 32'h80);
        tick();
        chk("bp_drain1", pc_id_o, 32'h84);

        // Fetch error at 0x84 stops fetching until redirect
        redirect(3'd0, '0);
        wait_valid(1'b0, 32'h84, 32'h84, ok);
        chk("err_seen", 32'(ok), 32'd1);
        chk("err_flag", 32'(instr_fetch_err_o), 32'd1);
        id_in_ready_i = 1'b0; instr_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            auto_rvalid(32'hFFFF_FFFF);
            tick();
        end
        instr_rvalid_i = 1'b0;
        #1;
        chk("err_req_stopped", 32'(instr_req_o), 32'd0);
        id_in_ready_i = 1'b1;
        redirect(3'd1, 32'h300);
        #1;
        chk("err_resume_req", 32'(instr_req_o), 32'd1);
        chk("err_resume_addr", instr_addr_o, 32'h300);
        tick();

        // Reset with a request outstanding, then a stray response
        instr_gnt_i = 1'b0;
        redirect(3'd0, '0);
        instr_gnt_i = 1'b1;
        tick();
        req_i = 1'b0; instr_gnt_i = 1'b0; rst_ni = 1'b0;
        tick();
        chk("mrst_req", 32'(instr_req_o), 32'd0);
        chk("mrst_addr", instr_addr_o, 32'd0);
        chk("mrst_valid", 32'(instr_valid_id_o), 32'd0);
        chk("mrst_rdata", instr_rdata_id_o, 32'd0);
        chk("mrst_pc", pc_id_o, 32'd0);
        chk("mrst_err", 32'(instr_fetch_err_o), 32'd0);
        chk("mrst_busy", 32'(if_busy_o), 32'd0);
        rst_ni = 1'b1; instr_rvalid_i = 1'b1;
        tick();
        instr_rvalid_i = 1'b0;
        tick();
        chk("stray_not_presented", 32'(instr_valid_id_o), 32'd0);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            req_i               = ($urandom_range(7) != 0);
            pc_set_i            = ($urandom_range(19) == 0);
            pc_mux_i            = 3'($urandom_range(7));
            exc_pc_mux_i        = 2'($urandom_range(3));
            exc_cause_i         = 6'($urandom);
            boot_addr_i         = $urandom;
            jump_target_i       = $urandom;
            csr_mtvec_i         = $urandom;
            csr_mepc_i          = $urandom;
            csr_depc_i          = $urandom;
            instr_gnt_i         = 1'($urandom_range(1));
            instr_rvalid_i      = (m_out.size() != 0) && ($urandom_range(1) == 1);
            instr_err_i         = instr_rvalid_i && ($urandom_range(15) == 0);
            id_in_ready_i       = ($urandom_range(3) != 0);
            instr_valid_clear_i = ($urandom_range(7) == 0);
            tick();
        end

        req_i = 1'b0; pc_set_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
        instr_err_i = 1'b0; id_in_ready_i = 1'b0; instr_valid_clear_i = 1'b0;
        tick(); tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ibex_fetch_unit.md
Name: ibex_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the ID-stage controller.
- Generates fetch addresses from the controller's pc_set/pc_mux/exc_pc_mux commands.
- Drives the instruction-memory request/grant/rvalid bus and buffers returned words in a small FIFO.
- Presents one instruction at a time to ID via a valid/ready-style ID register.

Parameters:
- FIFO_DEPTH, 2, entries in response FIFO; also the maximum number of outstanding requests (≥2).
- DM_HALT_ADDR, 32'h1A110800, debug-mode entry address (EXC_PC_DBD).
- DM_EXC_ADDR, 32'h1A110808, exception-in-debug address (EXC_PC_DBG_EXC).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_i  in  1  controller permits fetching (controller's instr_req)
- pc_set_i  in  1  redirect fetch this cycle
- pc_mux_i  in  3  0 BOOT, 1 JUMP, 2 EXC, 3 ERET, 4 DRET
- exc_pc_mux_i  in  2  0 EXC, 1 IRQ, 2 DBD, 3 DBG_EXC
- exc_cause_i  in  6  cause; bits[4:0] select vectored IRQ slot
- boot_addr_i  in  32  boot base
- jump_target_i  in  32  branch/jump target from EX
- csr_mtvec_i  in  32  trap vector base; bits[7:0] ignored
- csr_mepc_i  in  32  MRET target
- csr_depc_i  in  32  DRET target
- instr_req_o  out  1  memory request
- instr_addr_o  out  32  word-aligned request address
- instr_gnt_i  in  1  request accepted
- instr_rvalid_i  in  1  response valid
- instr_rdata_i  in  32  response data
- instr_err_i  in  1  bus error, qualified by rvalid
- id_in_ready_i  in  1  ID accepts a new instruction
- instr_valid_clear_i  in  1  ID consumed/flushed its instruction
- instr_valid_id_o  out  1  ID register holds an instruction
- instr_rdata_id_o  out  32  instruction word
- pc_id_o  out  32  PC of instruction in ID
- instr_fetch_err_o  out  1  instruction in ID came from an errored fetch
- if_busy_o  out  1  requests outstanding or request pending

Behaviour:
- Reset (rst_ni low at posedge): fetch_addr_q=0, FIFO empty, outstanding=0, discard=0, err_stop=0, all outputs 0. Reset mid-transaction abandons outstanding responses with no bookkeeping.
- Redirect target:
  - BOOT → boot_addr_i+0x80
  - JUMP → jump_target_i
  - ERET → csr_mepc_i
  - DRET → csr_depc_i
  - EXC/EXC → {mtvec[31:8],8'h00}
  - EXC/IRQ → {mtvec[31:8],1'b0,exc_cause_i[4:0],2'b00}
  - EXC/DBD → DM_HALT_ADDR
  - EXC/DBG_EXC → DM_EXC_ADDR
  - Undefined pc_mux values → BOOT.
  - Target bits[1:0] forced to 0.
- pc_set_i at cycle N:
  - fetch_addr_q loads the target.
  - FIFO is emptied.
  - ID valid clears.
  - err_stop clears.
  - discard := outstanding minus any rvalid in N.
  - instr_req_o is 0 in cycle N; the new address is presented from N+1.
- Request rule: instr_req_o = req_i & ~pc_set_i & ~err_stop & (outstanding + fifo_count < FIFO_DEPTH).
  - instr_addr_o = fetch_addr_q.
  - On req&gnt: fetch_addr_q += 4 (wraps modulo 2^32) and outstanding++.
  - If req drops without gnt, nothing changes.
- Response rule: rvalid decrements outstanding; req&gnt and rvalid in the same cycle leaves outstanding unchanged.
  - If discard>0: the response is dropped and discard decrements.
  - Otherwise the entry {rdata, err, pc} is accepted, with pc = address of the oldest live request.
- Error rule: an accepted entry with err=1 sets err_stop; no further requests until the next pc_set_i.
- ID register:
  - Loads when id_in_ready_i and an entry is available (FIFO head, or a bypassed accepted response when the FIFO is empty); valid=1 next cycle.
  - Otherwise, if instr_valid_clear_i, valid=0.
  - pc_set_i has priority over both.
- Latency: pc_set at N, gnt at N+1, rvalid at N+2, FIFO empty and ready high → instr_valid_id_o=1 at N+3.
- FIFO: full means no write occurs, because the request rule guarantees space. Empty with no response means ID keeps its current contents.
- if_busy_o = instr_req_o | (outstanding != 0).

Test Plan:
- Boot: boot_addr=0x0, pc_set, mux=BOOT, gnt and rvalid immediate, ready=1 → addresses 0x80, 0x84, 0x88; instr_valid_id_o at N+3 with pc_id_o=0x80.
- IRQ vector: mtvec=0x0000_1000, exc_cause=6'h27, EXC/IRQ → instr_addr_o=0x101C in N+1.
- Flush with 2 outstanding: pc_set mux=JUMP target=0x200 → next 2 rvalids dropped; first ID instruction has pc 0x200 and the new data.
- Backpressure: ready=0, gnt=1 always → exactly 2 grants, then instr_req_o=0; raising ready drains the FIFO in order with pcs 0x80 then 0x84.
- Fetch error: rvalid with err=1 at 0x84 → instr_fetch_err_o=1 with pc_id_o=0x84, requests stop; pc_set to 0x300 resumes fetching.
- Reset mid-fetch: rst_ni low with 1 outstanding → all outputs 0 next cycle; a stray rvalid after reset is not presented to ID.
